regfile_nbits: RTL and testbench
================================

# regfile_nbits

Parametrised register file generalising the single N-bit enabled register into DEPTH words of WIDTH bits. It has one synchronous write port, two registered read ports with write-to-read bypass, a synchronous clear-all and a per-word valid vector. It serves as the small general-purpose storage block for datapath exercises that previously instantiated several single registers by hand.

## Interface
Parameters:
- WIDTH, default 4: bits per word; minimum 1.
- DEPTH, default 4: number of words; power of two, minimum 2.
- AW, default $clog2(DEPTH): address width; derived, never overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 clears the block immediately, independent of clk).
- en  input  1  global enable; when 0 all state holds, including rdata_a, rdata_b and valid.
- clr  input  1  synchronous clear-all of storage and valid; qualified by en.
- we  input  1  write enable; qualified by en.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rdata_b  output  WIDTH  registered read data, port B.
- valid  output  DEPTH  bit i = 1 when word i has been written since the last reset or clr.

## Operation
- Storage: DEPTH x WIDTH flops, mem[0..DEPTH-1]. No other hidden state.
- Reset (reset = 0): every mem word = 0, rdata_a = 0, rdata_b = 0, valid = 0. The reset takes effect asynchronously and holds while reset is low. Release is sampled on the next rising edge.
- The following apply per rising edge with reset = 1, in priority order:
  1. en = 0: nothing changes. we, clr and the addresses are ignored.
  2. en = 1, clr = 1: all mem words = 0 and valid = 0. we is ignored. rdata_a and rdata_b load 0.
  3. en = 1, clr = 0, we = 1: mem[waddr] = wdata and valid[waddr] = 1. All other words and valid bits hold.
  4. en = 1, clr = 0, we = 0: storage and valid hold.
- Read, when en = 1 and clr = 0, each port independently:
  - rdata_x loads wdata if we = 1 and raddr_x == waddr (bypass).
  - Otherwise rdata_x loads mem[raddr_x] (pre-edge contents).
- Both ports may address the same word; both return identical data.
- Reading an unwritten word returns 0, because storage is zeroed at reset and clr. valid lets a consumer distinguish "written 0" from "never written".
- Address range: AW bits exactly cover DEPTH, so no out-of-range addresses exist and no wrap logic is needed.

## Timing
- Write latency: 1 edge. Data written at edge k is stored after edge k.
- Read latency: 1 edge. Address presented before edge k gives rdata valid after edge k.
- Bypass: read-after-write in the same edge returns the new data, with no stale cycle.
- Back-to-back: a write at edge k and a read of the same address at edge k+1 return the written data.
- clr: takes effect at the edge on which it is sampled. A write in the same edge is lost.
- valid updates on the same edge as the corresponding write or clear.
- reset asserted mid-operation: all outputs go to 0 without waiting for clk. Any write in flight is discarded.
- Outputs change only on the rising clk edge or on reset assertion. There are no combinational paths from inputs to outputs.

## Test plan
Default parameters (WIDTH = 4, DEPTH = 4) unless stated.
- Reset: hold reset = 0 for 2 cycles with random inputs -> rdata_a = rdata_b = 0 and valid = 4'b0000 throughout. Pulse reset low between edges after writes -> outputs drop to 0 immediately.
- Write then read: en = 1, write 4'hA to addr 1 and 4'h5 to addr 2 on consecutive edges, then set raddr_a = 1 and raddr_b = 2 -> rdata_a = 4'hA and rdata_b = 4'h5 one edge later; valid = 4'b0110.
- Bypass: we = 1, waddr = 3, wdata = 4'hC, raddr_a = 3, raddr_b = 0 on the same edge -> after that edge rdata_a = 4'hC and rdata_b = 0.
- Enable gating: with mem[1] = 4'hA, set en = 0, we = 1, waddr = 1, wdata = 4'hF, raddr_a = 2 for 3 edges -> mem[1] stays 4'hA and rdata_a is unchanged. Re-enable and read addr 1 -> 4'hA.
- Clear priority: clr = 1 and we = 1 (waddr = 0, wdata = 4'h7) on the same edge -> valid = 0, all words read 0, rdata_a = rdata_b = 0.
- Parameter sweep: WIDTH = 8, DEPTH = 8; write each address i with data 8'h10 + i, then read all pairs (i, 7 − i) -> exact data match; valid = 8'hFF after all writes.

Source files
------------

// File: rtl/regfile_nbits.sv
// regfile_nbits: DEPTH x WIDTH register file.
// One synchronous write port, two registered read ports with same-edge
// write-to-read bypass, a synchronous clear-all and a per-word valid vector.
// A global enable freezes every piece of state, including the read registers.
// Storage is built from flops rather than block RAM because clear-all must
// zero every word in a single edge.
module regfile_nbits #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [DEPTH-1:0] valid
);

    // Architectural state
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [WIDTH-1:0] rdata_a_reg;
    logic [WIDTH-1:0] rdata_b_reg;

    // Next-state values, applied only when en is high
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic [DEPTH-1:0] valid_next;
    logic [WIDTH-1:0] rdata_a_next;
    logic [WIDTH-1:0] rdata_b_next;

    // Per-word write decode: clear wins over write, otherwise the addressed
    // word takes wdata and becomes valid; every other word holds.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [AW-1:0] WORD_ADDR = AW'(gi);
            logic word_wr;

            assign word_wr        = we && (waddr == WORD_ADDR);
            assign mem_next[gi]   = clr ? '0 : (word_wr ? wdata : mem_reg[gi]);
            assign valid_next[gi] = clr ? 1'b0 : (word_wr | valid_reg[gi]);
        end
    endgenerate

    // Read port A: bypass the incoming write so read-after-write has no stale cycle
    always_comb begin
        rdata_a_next = mem_reg[raddr_a];
        if (we && (raddr_a == waddr)) begin
            rdata_a_next = wdata;
        end
        if (clr) begin
            rdata_a_next = '0;
        end
    end

    // Read port B: same bypass and clear behaviour as port A
    always_comb begin
        rdata_b_next = mem_reg[raddr_b];
        if (we && (raddr_b == waddr)) begin
            rdata_b_next = wdata;
        end
        if (clr) begin
            rdata_b_next = '0;
        end
    end

    // State register: async active-low reset zeroes everything, en gates all updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            valid_reg   <= '0;
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= mem_next[i];
            end
            valid_reg   <= valid_next;
            rdata_a_reg <= rdata_a_next;
            rdata_b_reg <= rdata_b_next;
        end
    end

    // Outputs come straight from flops; no input-to-output combinational path
    assign rdata_a = rdata_a_reg;
    assign rdata_b = rdata_b_reg;
    assign valid   = valid_reg;

endmodule

// File: tb/tb_regfile_nbits.sv
// Testbench for regfile_nbits: a default 4x4 instance and an 8x8 instance.
// The stimulus process pushes hand-computed expectations tagged with the
// cycle after which they must hold; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_regfile_nbits;

    logic clk;
    logic reset;

    // 4x4 instance signals
    logic       en, clr, we;
    logic [1:0] waddr, raddr_a, raddr_b;
    logic [3:0] wdata, rdata_a, rdata_b, valid;

    // 8x8 instance signals
    logic       en8, clr8, we8;
    logic [2:0] waddr8, raddr_a8, raddr_b8;
    logic [7:0] wdata8, rdata_a8, rdata_b8, valid8;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;

    typedef struct {
        int          cyc;
        bit          wide;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [7:0]  vld;
        string       name;
    } exp_t;

    exp_t sb[$];

    regfile_nbits #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .we(we),
        .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .valid(valid)
    );

    regfile_nbits #(.WIDTH(8), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .clr(clr8), .we(we8),
        .waddr(waddr8), .wdata(wdata8), .raddr_a(raddr_a8), .raddr_b(raddr_b8),
        .rdata_a(rdata_a8), .rdata_b(rdata_b8), .valid(valid8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] a_ra, a_rb, a_v;
        while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cycle_cnt) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         e.name, e.cyc, cycle_cnt);
            end else begin
                if (e.wide) begin
                    a_ra = rdata_a8; a_rb = rdata_b8; a_v = valid8;
                end else begin
                    a_ra = {4'h0, rdata_a}; a_rb = {4'h0, rdata_b}; a_v = {4'h0, valid};
                end
                if (a_ra !== e.ra || a_rb !== e.rb || a_v !== e.vld) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got ra=%h rb=%h valid=%h, expected ra=%h rb=%h valid=%h",
                             e.name, cycle_cnt, a_ra, a_rb, a_v, e.ra, e.rb, e.vld);
                end else begin
                    $display("ok   %s cyc=%0d ra=%h rb=%h valid=%h",
                             e.name, cycle_cnt, a_ra, a_rb, a_v);
                end
            end
        end
    end

    task automatic exp4(input string nm, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] v);
        exp_t e;
        e.cyc = cycle_cnt + 1; e.wide = 1'b0;
        e.ra = {4'h0, ra}; e.rb = {4'h0, rb}; e.vld = {4'h0, v}; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp8(input string nm, input logic [7:0] ra, input logic [7:0] rb,
                        input logic [7:0] v);
        exp_t e;
        e.cyc = cycle_cnt + 1; e.wide = 1'b1;
        e.ra = ra; e.rb = rb; e.vld = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Immediate check for the asynchronous reset, which is not edge-aligned
    task automatic check_now(input string nm);
        checks++;
        if (rdata_a !== 4'h0 || rdata_b !== 4'h0 || valid !== 4'h0) begin
            failures++;
            $display("FAIL %s: got ra=%h rb=%h valid=%h, expected all 0",
                     nm, rdata_a, rdata_b, valid);
        end else begin
            $display("ok   %s ra=%h rb=%h valid=%h", nm, rdata_a, rdata_b, valid);
        end
    endtask

    task automatic set4(input logic e, input logic c, input logic w, input logic [1:0] wa,
                        input logic [3:0] wd, input logic [1:0] ra, input logic [1:0] rb);
        en = e; clr = c; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        en8 = 1'b0; clr8 = 1'b0; we8 = 1'b0; waddr8 = '0; wdata8 = '0;
        raddr_a8 = '0; raddr_b8 = '0;

        // Reset held low for two edges with random inputs
        for (int i = 0; i < 2; i++) begin
            set4(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                 4'($urandom), 2'($urandom), 2'($urandom));
            exp4("reset_hold", 4'h0, 4'h0, 4'h0);
            tick();
        end
        check_now("reset_level");

        // Release reset; write A to addr 1
        reset = 1'b1;
        set4(1, 0, 1, 2'd1, 4'hA, 2'd0, 2'd0);
        exp4("write_a", 4'h0, 4'h0, 4'b0010);
        tick();
        // Write 5 to addr 2, read addr 1 back-to-back
        set4(1, 0, 1, 2'd2, 4'h5, 2'd1, 2'd0);
        exp4("b2b_read", 4'hA, 4'h0, 4'b0110);
        tick();
        // Plain read of both written words
        set4(1, 0, 0, 2'd0, 4'h0, 2'd1, 2'd2);
        exp4("read_ab", 4'hA, 4'h5, 4'b0110);
        tick();
        // Bypass on port A, port B reads unwritten word 0
        set4(1, 0, 1, 2'd3, 4'hC, 2'd3, 2'd0);
        exp4("bypass", 4'hC, 4'h0, 4'b1110);
        tick();
        // Enable gating: write attempts and read address changes ignored
        for (int i = 0; i < 3; i++) begin
            set4(0, 0, 1, 2'd1, 4'hF, 2'd2, 2'd1);
            exp4("en_hold", 4'hC, 4'h0, 4'b1110);
            tick();
        end
        // Re-enable: word 1 must still hold A
        set4(1, 0, 0, 2'd0, 4'h0, 2'd1, 2'd3);
        exp4("reenable", 4'hA, 4'hC, 4'b1110);
        tick();
        // Both ports on the same word
        set4(1, 0, 0, 2'd0, 4'h0, 2'd2, 2'd2);
        exp4("same_addr", 4'h5, 4'h5, 4'b1110);
        tick();
        // Clear beats write
        set4(1, 1, 1, 2'd0, 4'h7, 2'd1, 2'd2);
        exp4("clr_prio", 4'h0, 4'h0, 4'b0000);
        tick();
        set4(1, 0, 0, 2'd0, 4'h0, 2'd0, 2'd1);
        exp4("clr_read01", 4'h0, 4'h0, 4'b0000);
        tick();
        set4(1, 0, 0, 2'd0, 4'h0, 2'd2, 2'd3);
        exp4("clr_read23", 4'h0, 4'h0, 4'b0000);
        tick();
        // Written zero is distinguishable via valid
        set4(1, 0, 1, 2'd2, 4'h0, 2'd2, 2'd2);
        exp4("write_zero", 4'h0, 4'h0, 4'b0100);
        tick();
        // Write 9 to addr 1 with bypass read
        set4(1, 0, 1, 2'd1, 4'h9, 2'd1, 2'd2);
        exp4("pre_async", 4'h9, 4'h0, 4'b0110);
        tick();
        // Async reset between edges, with a write presented during reset
        set4(1, 0, 1, 2'd3, 4'hE, 2'd3, 2'd1);
        #2 reset = 1'b0;
        #1 check_now("async_reset");
        exp4("reset_write_lost", 4'h0, 4'h0, 4'b0000);
        tick();
        reset = 1'b1;
        set4(1, 0, 0, 2'd0, 4'h0, 2'd1, 2'd3);
        exp4("post_reset", 4'h0, 4'h0, 4'b0000);
        tick();
        // en = 0 also blocks clr
        set4(1, 0, 1, 2'd3, 4'h6, 2'd3, 2'd0);
        exp4("write_6", 4'h6, 4'h0, 4'b1000);
        tick();
        set4(0, 1, 0, 2'd0, 4'h0, 2'd0, 2'd0);
        exp4("en_blocks_clr", 4'h6, 4'h0, 4'b1000);
        tick();
        set4(0, 0, 0, 2'd0, 4'h0, 2'd0, 2'd0);

        // 8x8 sweep: write i with 8'h10+i while reading (i, 7-i)
        en8 = 1'b1; we8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            waddr8 = 3'(i); wdata8 = 8'(8'h10 + i);
            raddr_a8 = 3'(i); raddr_b8 = 3'(7 - i);
            exp8("sweep_write", 8'(8'h10 + i),
                 ((7 - i) < i) ? 8'(8'h10 + 7 - i) : 8'h00,
                 8'((16'd1 << (i + 1)) - 1));
            tick();
        end
        we8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a8 = 3'(i); raddr_b8 = 3'(7 - i);
            exp8("sweep_read", 8'(8'h10 + i), 8'(8'h17 - i), 8'hFF);
            tick();
        end

        tick();
        tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", e.name, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
